// File: rtl/race_sort_controller.sv
// race_sort_controller: clocked start/done wrapper around the race-logic
// bitonic sorter. Binary values become timed falling edges on raw_in, and
// falling edges seen on sorted_out are timestamped back into binary.
module race_sort_controller #(
  parameter int N    = 16,
  parameter int W    = 6,
  parameter int LAT  = 0,
  parameter int REST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] values_in,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] results_out,
  output logic           error,
  output logic [N-1:0]   raw_in,
  input  logic [N-1:0]   sorted_out
);

  localparam int TW  = W + 1;
  localparam int RCW = (REST > 1) ? $clog2(REST) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((1 << W) - 1 + LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH, S_REST} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  t;
  logic [TW-1:0]  t_inc;
  logic [W-1:0]   val       [N];
  logic [W-1:0]   result    [N];
  logic [W-1:0]   res_final [N];
  logic [W-1:0]   cap_ts;
  logic [N-1:0]   flag;
  logic [N-1:0]   cap_now;
  logic [N-1:0]   missing;
  logic [RCW-1:0] rest_cnt;
  logic           run_last;
  logic           rest_last;

  // State register; a synchronous reset aborts any run in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the status outputs decoded from the state.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (run_last) state_nxt = S_FINISH;
      S_FINISH: state_nxt = (REST == 0) ? S_IDLE : S_REST;
      S_REST:   if (rest_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture decode: which sorter outputs fall this cycle, and the result
  // vector as it will look once this cycle's captures are folded in.
  always_comb begin
    run_last  = (state == S_RUN) && (t == T_LAST);
    rest_last = (rest_cnt == RCW'(REST - 1));
    t_inc     = t + 1'b1;
    cap_ts    = W'(t - TW'(LAT));
    for (int j = 0; j < N; j++) begin
      cap_now[j]   = !sorted_out[j] && !flag[j];
      missing[j]   = sorted_out[j] && !flag[j];
      res_final[j] = cap_now[j] ? cap_ts : (flag[j] ? result[j] : '1);
    end
  end

  // Control datapath: time counter, capture flags, line drive, committed results.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_in      <= '1;
      results_out <= '0;
      error       <= 1'b0;
      t           <= '0;
      flag        <= '0;
      rest_cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            t    <= '0;
            flag <= '0;
            // First RUN cycle is k = 0: only zero-valued lanes fall.
            for (int i = 0; i < N; i++)
              raw_in[i] <= (values_in[i*W +: W] != '0);
          end
        end
        S_RUN: begin
          t    <= t_inc;
          flag <= flag | cap_now;
          if (!run_last) begin
            // Lines only ever fall during a run, giving one edge per lane.
            for (int i = 0; i < N; i++)
              if ({1'b0, val[i]} <= t_inc) raw_in[i] <= 1'b0;
          end else begin
            // Commit on entry to FINISH so done and results coincide.
            for (int j = 0; j < N; j++)
              results_out[j*W +: W] <= res_final[j];
            error <= |missing;
          end
        end
        S_FINISH: begin
          raw_in   <= '1;
          rest_cnt <= '0;
        end
        S_REST:  rest_cnt <= rest_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Value and timestamp storage; contents are only meaningful inside a run.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; each run writes val on
    // the accepted start and result before it is read, so a reset adds nothing.
    if (state == S_IDLE && start) begin
      for (int i = 0; i < N; i++) val[i] <= values_in[i*W +: W];
    end
    if (state == S_RUN) begin
      for (int j = 0; j < N; j++)
        if (cap_now[j]) result[j] <= cap_ts;
    end
  end

endmodule

// File: tb/tb_race_sort_controller.sv
// Bench for race_sort_controller: a behavioural race sorter drives
// sorted_out, and a sort-based reference model predicts every run.
module tb_race_sort_controller;

  localparam int N       = 16;
  localparam int W       = 6;
  localparam int LAT     = 0;
  localparam int REST    = 4;
  localparam int RUN_LEN = (1 << W) + LAT;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] values_in;
  logic           busy;
  logic           done;
  logic [N*W-1:0] results_out;
  logic           error;
  logic [N-1:0]   raw_in;
  logic [N-1:0]   sorted_out;

  bit             stuck15 = 1'b0;
  int             n_low;
  int             n_vec = 0;
  int             n_bad = 0;
  logic [N*W-1:0] last_results = '0;
  logic           last_error   = 1'b0;

  race_sort_controller #(.N(N), .W(W), .LAT(LAT), .REST(REST)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .values_in   (values_in),
    .busy        (busy),
    .done        (done),
    .results_out (results_out),
    .error       (error),
    .raw_in      (raw_in),
    .sorted_out  (sorted_out)
  );

  always #5 clk = ~clk;

  // Ideal race sorter: output j is low once at least j+1 inputs are low.
  always_comb begin
    n_low = 0;
    for (int i = 0; i < N; i++) n_low = n_low + (raw_in[i] ? 0 : 1);
    for (int j = 0; j < N; j++) sorted_out[j] = !(n_low > j);
    if (stuck15) sorted_out[N-1] = 1'b1;
  end

  task automatic test_reset;
    rst       = 1'b1;
    start     = 1'b0;
    values_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (raw_in !== 16'hFFFF) begin
      n_bad++; $display("FAIL reset_raw_in got %h expected ffff", raw_in);
    end
    n_vec++;
    if ({busy, done, error} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags busy/done/error got %b expected 000", {busy, done, error});
    end
    n_vec++;
    if (results_out !== '0) begin
      n_bad++; $display("FAIL reset_results got %h expected 0", results_out);
    end
    rst          = 1'b0;
    last_results = '0;
    last_error   = 1'b0;
  endtask

  // One complete run, started from an IDLE cycle at a negedge. With poke set,
  // start is also pulsed at k = 10 and on the done cycle; both must be ignored.
  task automatic do_run(input string name, input logic [N*W-1:0] vals, input bit poke);
    int             q[$];
    logic [N*W-1:0] exp_res;
    logic           exp_err;
    logic [N-1:0]   exp_raw;
    int             k;
    for (int i = 0; i < N; i++) q.push_back(int'(vals[i*W +: W]));
    q.sort();
    for (int j = 0; j < N; j++) exp_res[j*W +: W] = W'(q[j]);
    if (stuck15) exp_res[(N-1)*W +: W] = '1;
    exp_err   = stuck15;
    values_in = vals;
    start     = 1'b1;
    for (int c = 1; c <= RUN_LEN + 1 + REST + 1; c++) begin
      @(negedge clk);
      start = poke && (c == 11 || c == RUN_LEN + 1);
      if (c <= RUN_LEN) begin
        k = c - 1;
        for (int i = 0; i < N; i++) exp_raw[i] = !(int'(vals[i*W +: W]) <= k);
        n_vec++;
        if (raw_in !== exp_raw) begin
          n_bad++; $display("FAIL %s raw_in k=%0d got %h expected %h", name, k, raw_in, exp_raw);
        end
        n_vec++;
        if ({busy, done} !== 2'b10) begin
          n_bad++; $display("FAIL %s run_status k=%0d busy/done got %b expected 10", name, k, {busy, done});
        end
        if (c == RUN_LEN / 2) begin
          n_vec++;
          if ({error, results_out} !== {last_error, last_results}) begin
            n_bad++; $display("FAIL %s hold_previous got %h/%b expected %h/%b",
                              name, results_out, error, last_results, last_error);
          end
        end
      end else if (c == RUN_LEN + 1) begin
        n_vec++;
        if ({busy, done} !== 2'b11) begin
          n_bad++; $display("FAIL %s done_timing busy/done got %b expected 11", name, {busy, done});
        end
        n_vec++;
        if (results_out !== exp_res) begin
          n_bad++; $display("FAIL %s results got %h expected %h", name, results_out, exp_res);
        end
        n_vec++;
        if (error !== exp_err) begin
          n_bad++; $display("FAIL %s error got %b expected %b", name, error, exp_err);
        end
        last_results = exp_res;
        last_error   = exp_err;
      end else if (c <= RUN_LEN + 1 + REST) begin
        n_vec++;
        if ({busy, done, raw_in} !== {2'b10, 16'hFFFF}) begin
          n_bad++; $display("FAIL %s rest busy/done/raw_in got %b/%b/%h expected 1/0/ffff",
                            name, busy, done, raw_in);
        end
      end else begin
        n_vec++;
        if ({busy, done, raw_in} !== {2'b00, 16'hFFFF}) begin
          n_bad++; $display("FAIL %s idle busy/done/raw_in got %b/%b/%h expected 0/0/ffff",
                            name, busy, done, raw_in);
        end
      end
    end
  endtask

  function automatic logic [N*W-1:0] random_values();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    return v;
  endfunction

  task automatic test_mixed;
    int             mv[N] = '{41, 5, 30, 20, 15, 10, 43, 17, 35, 44, 26, 37, 11, 7, 40, 21};
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(mv[i]);
    do_run("mixed", v, 1'b0);
  endtask

  task automatic test_boundaries;
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = (i < 8) ? '0 : '1;
    do_run("bound_ties", v, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_run("busy_poke", random_values(), 1'b1);
    do_run("accept_after_rest", random_values(), 1'b0);
  endtask

  task automatic test_reset_mid_run;
    logic [N*W-1:0] v;
    values_in = random_values();
    start     = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done, raw_in} !== {2'b00, 16'hFFFF}) begin
      n_bad++; $display("FAIL midreset_abort busy/done/raw_in got %b/%b/%h expected 0/0/ffff",
                        busy, done, raw_in);
    end
    n_vec++;
    if ({error, results_out} !== '0) begin
      n_bad++; $display("FAIL midreset_results got %h/%b expected 0/0", results_out, error);
    end
    last_results = '0;
    last_error   = 1'b0;
    for (int c = 0; c < RUN_LEN + 8; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done} !== 2'b00) begin
        n_bad++; $display("FAIL midreset_quiet cycle=%0d busy/done got %b expected 00", c, {busy, done});
      end
    end
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(9);
    do_run("after_reset_nines", v, 1'b0);
  endtask

  task automatic test_stuck;
    stuck15 = 1'b1;
    do_run("stuck15", random_values(), 1'b0);
    stuck15 = 1'b0;
    do_run("stuck_recover", random_values(), 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) do_run("random", random_values(), 1'b0);
  endtask

  initial begin
    test_reset;
    @(negedge clk);
    test_mixed;
    test_boundaries;
    test_back_to_back;
    test_reset_mid_run;
    test_stuck;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
